// File: rtl/lsu_pkg.sv
// Shared encodings for the multi-cycle load/store unit: funct3 sizes, response
// error codes and the handshake FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Access size as log2(bytes); the low two funct3 bits encode it directly.
  function automatic logic [1:0] f3_size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: funct3 decode and legality, store strobes and
// lane-replicated write data, and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                req_funct3,
  input  logic                      req_we,
  input  logic [$clog2(XLEN/8)-1:0] req_off,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      illegal,
  output logic                      misaligned,
  output logic [XLEN/8-1:0]         strobe,
  output logic [XLEN-1:0]           wdata_rep,
  input  logic [2:0]                ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0] ld_off,
  input  logic [XLEN-1:0]           ld_raw,
  output logic [XLEN-1:0]           ld_data
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int LW    = $clog2(XLEN);

  logic [1:0]       sz;
  logic [3:0]       size_bytes;
  logic [NB-1:0]    size_mask;
  logic [OFF_W-1:0] align_mask;
  logic [XLEN-1:0]  ld_shift;
  logic [LW-1:0]    sign_idx;
  logic             ld_signed;

  assign sz         = f3_size_log2(req_funct3);
  assign size_bytes = 4'd1 << sz;

  // Unsigned variants only exist for loads; D/WU only exist on a 64-bit datapath.
  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_we;
      F3_D:             illegal = (XLEN != 64);
      F3_WU:            illegal = (XLEN != 64) || req_we;
      default:          illegal = 1'b1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < OFF_W; gi++) begin : g_align
      assign align_mask[gi] = (sz > 2'(gi));
    end
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign size_mask[gi] = (4'(gi) < size_bytes);
      assign wdata_rep[8*gi +: 8] = (sz == 2'd0) ? req_wdata[7:0] :
                                    (sz == 2'd1) ? req_wdata[8*(gi%2) +: 8] :
                                    (sz == 2'd2) ? req_wdata[8*(gi%4) +: 8] :
                                                   req_wdata[8*(gi%8) +: 8];
    end
  endgenerate

  assign misaligned = |(req_off & align_mask);
  assign strobe     = size_mask << req_off;

  assign ld_shift  = ld_raw >> {ld_off, 3'b000};
  assign ld_signed = ~ld_funct3[2];

  always_comb begin
    case (f3_size_log2(ld_funct3))
      2'd0:    sign_idx = LW'(7);
      2'd1:    sign_idx = LW'(15);
      2'd2:    sign_idx = LW'(31);
      default: sign_idx = LW'(XLEN - 1);
    endcase
  end

  // Bits above the access width are filled with the lane's sign bit or zero.
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_ext
      assign ld_data[gi] = (LW'(gi) <= sign_idx) ? ld_shift[gi]
                                                 : (ld_signed & ld_shift[sign_idx]);
    end
  endgenerate

endmodule

// File: rtl/lsu_handshake.sv
// Multi-cycle load/store unit: accepts one core request at a time, drives a
// variable-latency SRAM over a read/strobe + ack handshake, and returns a response pulse.
module lsu_handshake
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              data_read,
  output logic [XLEN/8-1:0] data_write,
  output logic [ADDR_W-1:0] data_addr,
  output logic [XLEN-1:0]   data_in,
  input  logic [XLEN-1:0]   data_out,
  input  logic              data_ack
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              data_read_q, data_read_d;
  logic [NB-1:0]     data_write_q, data_write_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [XLEN-1:0]   data_in_q, data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;

  logic              illegal, misaligned;
  logic [NB-1:0]     strobe;
  logic [XLEN-1:0]   wdata_rep, ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_funct3 (req_funct3),
    .req_we     (req_we),
    .req_off    (req_addr[OFF_W-1:0]),
    .req_wdata  (req_wdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .strobe     (strobe),
    .wdata_rep  (wdata_rep),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .ld_raw     (data_out),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    f3_d         = f3_q;
    we_d         = we_q;
    off_d        = off_q;
    data_read_d  = data_read_q;
    data_write_d = data_write_q;
    data_addr_d  = data_addr_q;
    data_in_d    = data_in_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          we_d  = req_we;
          off_d = req_addr[OFF_W-1:0];
          if (illegal || misaligned) begin
            // Rejected requests never touch the SRAM.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            state_d      = ACCESS;
            data_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            data_read_d  = ~req_we;
            data_write_d = req_we ? strobe : '0;
            if (req_we) data_in_d = wdata_rep;
          end
        end
      end
      ACCESS: begin
        if (data_ack) begin
          state_d      = RESP;
          data_read_d  = 1'b0;
          data_write_d = '0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = we_q ? '0 : ld_data;
          rsp_err_d    = ERR_OK;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d      = RESP;
          data_read_d  = 1'b0;
          data_write_d = '0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_err_d    = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      off_q        <= '0;
      data_read_q  <= 1'b0;
      data_write_q <= '0;
      data_addr_q  <= '0;
      data_in_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_OK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      off_q        <= off_d;
      data_read_q  <= data_read_d;
      data_write_q <= data_write_d;
      data_addr_q  <= data_addr_d;
      data_in_q    <= data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = (state_q == IDLE) & ~rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign data_read  = data_read_q;
  assign data_write = data_write_q;
  assign data_addr  = data_addr_q;
  assign data_in    = data_in_q;

endmodule
